// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder around full_adder_gate_level; SERIAL_ADD_SUB_EN adds a subtract mode.
// Start-to-done latency WIDTH+1 cycles; start is only honoured while ready, otherwise dropped.
module full_adder_gate_level (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;
  logic g;
  logic t;

  xor g_p   (p, a, b);
  xor g_sum (sum, p, cin);
  and g_g   (g, a, b);
  and g_t   (t, p, cin);
  or  g_co  (cout, g, t);
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is a + ~b + 1, so only the B and carry load values change.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder_gate_level u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sum_r  <= {fa_s, sum_r[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          cout_r <= fa_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry flop holds the carry into the MSB on this last bit
            ovf_r <= carry ^ fa_co;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_SHIFT);
  assign done  = (state == S_DONE);
  assign sum   = sum_r;
  assign cout  = cout_r;
  assign ovf   = ovf_r;
endmodule
